pulse_stretch: RTL and testbench
================================

Name: pulse_stretch

Overview:
- Converts single-cycle event pulses (e.g. from the game's level-to-pulse edge detector) back into timed level outputs.
- Each accepted pulse produces a high level on q lasting exactly HOLD_CYCLES cycles, followed by a guaranteed low gap of GAP_CYCLES cycles.
- Drives the stone-placed LED/buzzer in the gobang board.
- Pulses arriving while busy are queued in a saturating counter and replayed in order.

Parameters:
HOLD_CYCLES, 1000, clock cycles q stays high per event (>=1)
GAP_CYCLES, 500, minimum clock cycles q stays low between consecutive events (>=1)
PEND_W, 3, width of pending-event counter; max queued = 2^PEND_W-1

Ports:
clk  input  1  system clock, all logic on rising edge
rst_n  input  1  asynchronous active-low reset
p  input  1  event pulse, synchronous to clk; every cycle p=1 is one event
q  output  1  stretched level output, registered
busy  output  1  high when state != IDLE, registered
pend_cnt  output  PEND_W  number of queued events not yet started
overflow  output  1  one-cycle pulse when an event is dropped because the queue is full

Behaviour:
- Reset: async assert on rst_n=0. State=IDLE, q=0, busy=0, pend_cnt=0, overflow=0, timer=0. Reset mid-HOLD/GAP aborts immediately, and queued events are discarded.
- Timer width is $clog2(max(HOLD_CYCLES,GAP_CYCLES)+1). It counts down.
- States: IDLE, HOLD, GAP.
- IDLE:
  - p=1 sampled at edge k: state->HOLD, q=1 and busy=1 from edge k, timer loaded HOLD_CYCLES-1.
  - Latency from p to q is therefore 1 clock edge.
- HOLD:
  - q=1. Timer decrements each cycle.
  - At timer=0: state->GAP, q=0 on the next edge, timer loaded GAP_CYCLES-1.
  - q is high for exactly HOLD_CYCLES edges-to-edges.
- GAP:
  - q=0, busy=1. Timer decrements each cycle.
  - At timer=0 with pend_cnt>0: ->HOLD, q=1, pend_cnt decremented.
  - At timer=0 with pend_cnt=0: ->IDLE, busy=0.
  - q is low for exactly GAP_CYCLES cycles between events.
- Queueing: p=1 while state is HOLD or GAP.
  - If pend_cnt < max: pend_cnt+1.
  - If pend_cnt = max: pend_cnt holds at max and overflow=1 for one cycle.
- Simultaneous p=1 and dequeue (GAP end with pend_cnt>0): the new event is queued and one event is dequeued, so pend_cnt is unchanged. Overflow is never asserted in this case.
- Simultaneous p=1 and GAP end with pend_cnt=0: treated as the IDLE case. Go directly to HOLD with no extra idle cycle; pend_cnt stays 0.
- p held high for N cycles counts as N events.
- Outputs are never glitchy: all outputs come from flops.
- overflow defaults to 0 on every cycle it is not asserted.

Optional Feature:
- Macro: PULSE_STRETCH_RETRIGGER_EN.
- With the macro defined, p=1 during HOLD:
  - reloads timer to HOLD_CYCLES-1, extending q.
  - does not increment pend_cnt.
- p=1 during GAP still queues as above.
- Without the macro, p during HOLD queues as described.
- Port list is identical in both builds.

Test Plan:
Tests use HOLD_CYCLES=4, GAP_CYCLES=2, PEND_W=2.
- Single pulse: p=1 for one cycle at edge 10 -> q=1 on edges 10..13, q=0 from edge 14, busy=0 from edge 16, pend_cnt=0 throughout.
- Back-to-back queue: pulses at edges 10 and 12 -> pend_cnt=1 at edge 12; q high 10..13, low 14..15, high 16..19, pend_cnt=0 at edge 16; busy=0 from edge 22.
- Overflow: p=1 for 5 consecutive cycles from edge 10 -> pend_cnt saturates at 3 at edge 13; overflow=1 only at edge 14; exactly 4 q high-periods total.
- Simultaneous dequeue: pend_cnt=1, p=1 on the GAP-final cycle -> pend_cnt stays 1, q rises the next edge, no overflow.
- Async reset: rst_n=0 mid-HOLD with pend_cnt=2 -> q, busy, pend_cnt go to 0 immediately without a clock; a pulse after release gives a normal 4-cycle q.
- With PULSE_STRETCH_RETRIGGER_EN: pulses at edges 10 and 12 -> q high edges 10..15 (6 cycles), pend_cnt stays 0, then 2-cycle gap, then IDLE.

Source files
------------

// File: rtl/pulse_stretch.sv
// rtl/pulse_stretch.sv - stretches single-cycle event pulses into timed high levels with a queued replay
// Optional feature: define PULSE_STRETCH_RETRIGGER_EN so that a pulse during HOLD extends q instead of queueing.
module pulse_stretch #(
  parameter int HOLD_CYCLES = 1000,
  parameter int GAP_CYCLES  = 500,
  parameter int PEND_W      = 3
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p,
  output logic              q,
  output logic              busy,
  output logic [PEND_W-1:0] pend_cnt,
  output logic              overflow
);

  localparam int MAX_CYC = (HOLD_CYCLES > GAP_CYCLES) ? HOLD_CYCLES : GAP_CYCLES;
  localparam int TW      = $clog2(MAX_CYC + 1);
  localparam logic [TW-1:0]     HOLD_LD  = TW'(HOLD_CYCLES - 1);
  localparam logic [TW-1:0]     GAP_LD   = TW'(GAP_CYCLES - 1);
  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  state_t            state, state_n;
  logic [TW-1:0]     timer, timer_n;
  logic [PEND_W-1:0] pend_n;
  logic              ovf_n;
  logic              enq;

  always_comb begin
    state_n = state;
    timer_n = timer;
    pend_n  = pend_cnt;
    ovf_n   = 1'b0;
    enq     = 1'b0;
    case (state)
      IDLE: begin
        if (p) begin
          state_n = HOLD;
          timer_n = HOLD_LD;
        end
      end
      HOLD: begin
`ifdef PULSE_STRETCH_RETRIGGER_EN
        if (p) begin
          timer_n = HOLD_LD;
        end else if (timer == '0) begin
          state_n = GAP;
          timer_n = GAP_LD;
        end else begin
          timer_n = timer - 1'b1;
        end
`else
        enq = p;
        if (timer == '0) begin
          state_n = GAP;
          timer_n = GAP_LD;
        end else begin
          timer_n = timer - 1'b1;
        end
`endif
      end
      GAP: begin
        if (timer == '0) begin
          // A pulse on the dequeue cycle replaces the dequeued slot, so the count is unchanged.
          if (pend_cnt != '0) begin
            state_n = HOLD;
            timer_n = HOLD_LD;
            if (!p) pend_n = pend_cnt - 1'b1;
          end else if (p) begin
            state_n = HOLD;
            timer_n = HOLD_LD;
          end else begin
            state_n = IDLE;
          end
        end else begin
          timer_n = timer - 1'b1;
          enq     = p;
        end
      end
      default: state_n = IDLE;
    endcase
    if (enq) begin
      if (pend_cnt == PEND_MAX) ovf_n = 1'b1;
      else                      pend_n = pend_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      timer    <= '0;
      pend_cnt <= '0;
      q        <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      state    <= state_n;
      timer    <= timer_n;
      pend_cnt <= pend_n;
      q        <= (state_n == HOLD);
      busy     <= (state_n != IDLE);
      overflow <= ovf_n;
    end
  end

endmodule

// File: tb/tb_pulse_stretch.sv
// tb/tb_pulse_stretch.sv - self-checking bench for pulse_stretch against a timeline model
module tb_pulse_stretch;
  localparam int H    = 4;
  localparam int G    = 2;
  localparam int PW   = 2;
  localparam int PMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          p;
  logic          q, busy, overflow;
  logic [PW-1:0] pend_cnt;

  int vectors     = 0;
  int miscompares = 0;

  // Model: an event owns edges [start, hold_end) high, then G low edges; next may start at hold_end+G.
  bit m_active;
  int m_k, m_hold_end, m_pend;
  bit m_ovf;

  logic [31:0] qv, bv, ov;
  int          pend_tr[32];
  int          rises;
  int          dens;

  pulse_stretch #(.HOLD_CYCLES(H), .GAP_CYCLES(G), .PEND_W(PW)) dut (
    .clk(clk), .rst_n(rst_n), .p(p), .q(q), .busy(busy),
    .pend_cnt(pend_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_active = 1'b0; m_k = 0; m_hold_end = 0; m_pend = 0; m_ovf = 1'b0;
  endfunction

  function automatic void model_edge(input bit pv);
    m_k++;
    m_ovf = 1'b0;
    if (!m_active) begin
      if (pv) begin m_active = 1'b1; m_hold_end = m_k + H; end
    end else if (m_k == m_hold_end + G) begin
      if (m_pend > 0) begin
        m_hold_end = m_k + H;
        if (!pv) m_pend--;
      end else if (pv) m_hold_end = m_k + H;
      else m_active = 1'b0;
    end
`ifdef PULSE_STRETCH_RETRIGGER_EN
    else if (pv && m_k <= m_hold_end) m_hold_end = m_k + H;
`endif
    else if (pv) begin
      if (m_pend == PMAX) m_ovf = 1'b1;
      else m_pend++;
    end
  endfunction

  task automatic step(input logic pv);
    p = pv;
    @(posedge clk);
    model_edge(pv);
    #1;
    check("q", q, (m_active && m_k < m_hold_end));
    check("busy", busy, m_active);
    check("pend_cnt", pend_cnt, m_pend);
    check("overflow", overflow, m_ovf);
  endtask

  task automatic do_reset();
    p = 1'b0;
    rst_n = 1'b0;
    #2;
    model_reset();
    check("rst_q", q, 0);
    check("rst_busy", busy, 0);
    check("rst_pend", pend_cnt, 0);
    check("rst_ovf", overflow, 0);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run_seq(input logic [31:0] pat, input int n);
    qv = '0; bv = '0; ov = '0;
    for (int i = 0; i < n; i++) begin
      step(pat[i]);
      qv[i] = q; bv[i] = busy; ov[i] = overflow;
      pend_tr[i] = int'(pend_cnt);
    end
  endtask

  initial begin
    rst_n = 1'b1;
    p = 1'b0;
    #1;
    do_reset();

    // Single pulse
    run_seq(32'h1, 8);
    check("single_q", qv, 32'b0000_1111);
    check("single_busy", bv, 32'b0011_1111);

    // Back-to-back: second pulse two edges after the first
    do_reset();
    run_seq(32'b101, 14);
`ifdef PULSE_STRETCH_RETRIGGER_EN
    check("retrig_q", qv, 32'b00000000111111);
    check("retrig_busy", bv, 32'b00000011111111);
    check("retrig_pend_s2", pend_tr[2], 0);
`else
    check("b2b_q", qv, 32'b00001111001111);
    check("b2b_busy", bv, 32'b00111111111111);
    check("b2b_pend_s2", pend_tr[2], 1);
    check("b2b_pend_s6", pend_tr[6], 0);
`endif

`ifndef PULSE_STRETCH_RETRIGGER_EN
    // Overflow: five consecutive events into a three-deep queue
    do_reset();
    run_seq(32'h1F, 28);
    check("ovf_pend_s3", pend_tr[3], 3);
    check("ovf_pulse", ov, 32'h10);
    rises = 0;
    for (int i = 0; i < 28; i++)
      if (qv[i] && (i == 0 || !qv[i-1])) rises++;
    check("ovf_q_periods", rises, 4);
    check("ovf_idle_end", bv[27], 0);

    // Pulse on the GAP-final cycle while one event is queued
    do_reset();
    run_seq(32'b1000101, 14);
    check("simdq_q", qv, 32'b11001111001111);
    check("simdq_pend_s6", pend_tr[6], 1);
    check("simdq_ovf", ov, 0);
`endif

    // Pulse on the GAP-final cycle with an empty queue
    do_reset();
    run_seq(32'b1000001, 12);
    check("gapend_q", qv, 32'b001111001111);
    check("gapend_busy", bv, 32'hFFF);

    // Async reset mid-HOLD with a non-empty queue
    do_reset();
    run_seq(32'b0111, 4);
    check("async_pre_q", q, 1);
`ifndef PULSE_STRETCH_RETRIGGER_EN
    check("async_pre_pend", pend_cnt, 2);
`endif
    do_reset();
    run_seq(32'h1, 6);
    check("post_rst_q", qv, 32'b001111);

    // Randomized traffic at varying densities with rare resets
    for (int blk = 0; blk < 15; blk++) begin
      dens = int'($urandom_range(5, 70));
      for (int i = 0; i < 200; i++) begin
        if ($urandom_range(0, 399) == 0) do_reset();
        step($urandom_range(0, 99) < dens);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
